// File: rtl/bus_width_increase.sv
// Narrow-to-wide packer: N input beats (or fewer, closed by input_last) form one output word.
// Latency 1 from completing beat to output_valid; output register holds while !output_ready.
module bus_width_increase #(
    parameter int SIZE_IN       = 8,
    parameter int SIZE_OUT      = 32,
    parameter bit LITTLE_ENDIAN = 1'b1
) (
    input  logic                                     clk,
    input  logic                                     reset,
    output logic                                     input_ready,
    input  logic                                     input_valid,
    input  logic [SIZE_IN-1:0]                       input_data,
    input  logic                                     input_last,
    input  logic                                     output_ready,
    output logic                                     output_valid,
    output logic [SIZE_OUT-1:0]                      output_data,
    output logic [$clog2(SIZE_OUT/SIZE_IN+1)-1:0]    output_count
);
    localparam int N  = SIZE_OUT / SIZE_IN;
    localparam int CW = $clog2(N + 1);
    localparam int AW = (N > 1) ? $clog2(N) : 1;

    generate
        if ((SIZE_OUT % SIZE_IN) != 0 || N < 2) begin : g_bad_params
            $error("bus_width_increase: SIZE_OUT must be a multiple of SIZE_IN with ratio >= 2");
        end
    endgenerate

    logic [AW-1:0]       asm_cnt;
    logic [SIZE_OUT-1:0] asm_buf;
    logic [SIZE_OUT-1:0] merged;
    logic [AW-1:0]       chunk_idx;
    logic                slot_free;
    logic                completing;
    logic                accept;

    assign slot_free   = !output_valid || output_ready;
    assign completing  = input_last || (asm_cnt == AW'(N - 1));
    // A non-completing beat only touches the assembly buffer, so it never waits on the consumer.
    assign input_ready = slot_free || !completing;
    assign accept      = input_valid && input_ready;
    assign chunk_idx   = LITTLE_ENDIAN ? asm_cnt : (AW'(N - 1) - asm_cnt);

    always_comb begin
        merged = asm_buf;
        for (int i = 0; i < N; i++) begin
            if (chunk_idx == AW'(i)) begin
                merged[i*SIZE_IN +: SIZE_IN] = input_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            asm_cnt      <= '0;
            asm_buf      <= '0;
            output_valid <= 1'b0;
            output_data  <= '0;
            output_count <= '0;
        end else begin
            if (output_valid && output_ready) begin
                output_valid <= 1'b0;
            end
            if (accept) begin
                if (completing) begin
                    // Loading here overrides the drain above, so back-to-back words have no bubble.
                    output_valid <= 1'b1;
                    output_data  <= merged;
                    output_count <= CW'(asm_cnt) + CW'(1);
                    asm_cnt      <= '0;
                    asm_buf      <= '0;
                end else begin
                    asm_buf <= merged;
                    asm_cnt <= asm_cnt + AW'(1);
                end
            end
        end
    end
endmodule
